// File: rtl/uart_io_sched_if.sv
// Signal bundle between the UART byte link / CPU in-out ports and uart_io_sched.
// The slave modport is the scheduler's view; master is the surrounding system.
`timescale 1ns/1ps
interface uart_io_sched_if #(
    parameter int PTR_W = 13
);
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic           tx_busy;
    logic           req_in;
    logic [31:0]    in_word;
    logic           in_ack;
    logic           req_out;
    logic [7:0]     out_byte;
    logic           out_ack;
    logic [PTR_W:0] rx_count;
    logic           overflow;

    modport master (
        output rx_data, rx_valid, tx_busy, req_in, req_out, out_byte,
        input  tx_data, tx_ready, in_word, in_ack, out_ack, rx_count, overflow
    );

    modport slave (
        input  rx_data, rx_valid, tx_busy, req_in, req_out, out_byte,
        output tx_data, tx_ready, in_word, in_ack, out_ack, rx_count, overflow
    );
endinterface

// File: rtl/uart_io_sched.sv
// UART <-> CPU in/out sequencer: receive ring buffer with 32-bit little-endian
// word assembly, and a single-sender arbiter for the post-reset sync byte and CPU output.
`timescale 1ns/1ps
module uart_io_sched #(
    parameter int         DEPTH     = 8192,
    parameter int         PTR_W     = 13,
    parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
    input logic            clk,
    input logic            rstn,
    uart_io_sched_if.slave bus
);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IN_IDLE, IN_COLLECT, IN_DONE} in_state_t;
    typedef enum logic [2:0] {TX_SYNC, TX_SYNC_WAIT, TX_IDLE, TX_SEND, TX_WAIT, TX_ACK} tx_state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             rx_valid_q;
    logic             overflow_q;
    logic             push;
    logic             push_ok;
    logic             pop;

    in_state_t        in_state;
    in_state_t        in_next;
    logic [1:0]       idx;
    logic [31:0]      word_q;

    tx_state_t        tx_state;
    tx_state_t        tx_next;
    logic [7:0]       tx_data_q;
    logic             accept_out;

    // One byte per rising edge of rx_valid; full buffer drops it
    assign push    = bus.rx_valid && !rx_valid_q;
    assign push_ok = push && (count != FULL_COUNT);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Pops look at the registered count, so a byte written this cycle waits one cycle
    always_comb begin
        in_next = in_state;
        pop     = 1'b0;
        unique case (in_state)
            IN_IDLE: begin
                if (bus.req_in) begin
                    in_next = IN_COLLECT;
                end
            end
            IN_COLLECT: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (idx == 2'd3) begin
                        in_next = IN_DONE;
                    end
                end
            end
            IN_DONE: in_next = IN_IDLE;
            default: in_next = IN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_state <= IN_IDLE;
            idx      <= '0;
            word_q   <= '0;
        end else begin
            in_state <= in_next;
            if (in_state == IN_IDLE && bus.req_in) begin
                idx <= '0;
            end else if (pop) begin
                word_q[8*idx +: 8] <= mem[rd_ptr];
                idx                <= idx + 2'd1;
            end
        end
    end

    always_comb begin
        tx_next    = tx_state;
        accept_out = 1'b0;
        unique case (tx_state)
            TX_SYNC: begin
                if (bus.tx_busy) begin
                    tx_next = TX_SYNC_WAIT;
                end
            end
            TX_SYNC_WAIT: begin
                if (!bus.tx_busy) begin
                    tx_next = TX_IDLE;
                end
            end
            TX_IDLE: begin
                if (bus.req_out) begin
                    accept_out = 1'b1;
                    tx_next    = TX_SEND;
                end
            end
            TX_SEND: begin
                if (bus.tx_busy) begin
                    tx_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!bus.tx_busy) begin
                    tx_next = TX_ACK;
                end
            end
            TX_ACK:  tx_next = TX_IDLE;
            default: tx_next = TX_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state  <= TX_SYNC;
            tx_data_q <= SYNC_BYTE;
        end else begin
            tx_state <= tx_next;
            if (accept_out) begin
                tx_data_q <= bus.out_byte;
            end
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_ready = (tx_state == TX_SYNC) || (tx_state == TX_SEND);
    assign bus.out_ack  = (tx_state == TX_ACK);
    assign bus.in_ack   = (in_state == IN_DONE);
    assign bus.in_word  = word_q;
    assign bus.rx_count = count;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_io_sched.sv
// Directed bench for uart_io_sched: sync byte, word assembly, slow feed,
// overflow with pointer wrap, mid-collect reset and output during sync.
`timescale 1ns/1ps
module tb_uart_io_sched;
    localparam int DEPTH = 8192;
    localparam int PTR_W = 13;

    logic clk = 1'b0;
    logic rstn;
    int   vectors     = 0;
    int   miscompares = 0;
    logic ack_seen;

    uart_io_sched_if #(.PTR_W(PTR_W)) bus ();

    uart_io_sched #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W),
        .SYNC_BYTE(8'hAA)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.in_ack === 1'b1) ack_seen = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset(input string tag);
        logic [57:0] got;
        logic [57:0] exp;
        rstn         = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        bus.req_in   = 1'b0;
        bus.req_out  = 1'b0;
        bus.out_byte = 8'h00;
        tick();
        tick();
        got = {bus.tx_data, bus.tx_ready, bus.in_ack, bus.in_word, bus.out_ack, bus.rx_count, bus.overflow};
        exp = {8'hAA, 1'b1, 1'b0, 32'h0, 1'b0, 14'h0, 1'b0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
        rstn     = 1'b1;
        ack_seen = 1'b0;
    endtask

    task automatic test_sync();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.tx_ready, bus.tx_data} !== {1'b1, 8'hAA}) begin
                miscompares++;
                $display("FAIL sync_present[%0d]: got %h, expected %h", i, {bus.tx_ready, bus.tx_data}, {1'b1, 8'hAA});
            end
        end
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.tx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL sync_wait[%0d]: tx_ready got %b, expected 0", i, bus.tx_ready);
            end
        end
        bus.tx_busy = 1'b0;
        tick();
        vectors++;
        if (bus.tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_idle: tx_ready got %b, expected 0", bus.tx_ready);
        end
        // An out request now proves the FSM reached IDLE
        bus.req_out  = 1'b1;
        bus.out_byte = 8'h5A;
        tick();
        bus.out_byte = 8'hFF;
        vectors++;
        if ({bus.tx_ready, bus.tx_data} !== {1'b1, 8'h5A}) begin
            miscompares++;
            $display("FAIL idle_accept: got %h, expected %h", {bus.tx_ready, bus.tx_data}, {1'b1, 8'h5A});
        end
        tick();
        vectors++;
        if ({bus.tx_ready, bus.tx_data} !== {1'b1, 8'h5A}) begin
            miscompares++;
            $display("FAIL send_hold: got %h, expected %h", {bus.tx_ready, bus.tx_data}, {1'b1, 8'h5A});
        end
        bus.tx_busy = 1'b1;
        tick();
        vectors++;
        if ({bus.tx_ready, bus.out_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL send_wait: got %b, expected 00", {bus.tx_ready, bus.out_ack});
        end
        bus.tx_busy = 1'b0;
        tick();
        vectors++;
        if ({bus.tx_ready, bus.out_ack} !== 2'b01) begin
            miscompares++;
            $display("FAIL send_ack: got %b, expected 01", {bus.tx_ready, bus.out_ack});
        end
        bus.req_out = 1'b0;
        tick();
        vectors++;
        if (bus.out_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL send_ack_width: out_ack got %b, expected 0", bus.out_ack);
        end
    endtask

    task automatic test_word();
        push_byte(8'h78);
        push_byte(8'h56);
        push_byte(8'h34);
        push_byte(8'h12);
        vectors++;
        if (bus.rx_count !== 14'd4) begin
            miscompares++;
            $display("FAIL word_count: got %0d, expected 4", bus.rx_count);
        end
        ack_seen   = 1'b0;
        bus.req_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (ack_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL word_early_ack: got %b, expected 0", ack_seen);
        end
        tick();
        vectors++;
        if ({bus.in_ack, bus.in_word, bus.rx_count} !== {1'b1, 32'h12345678, 14'd0}) begin
            miscompares++;
            $display("FAIL word_result: got %h, expected %h", {bus.in_ack, bus.in_word, bus.rx_count}, {1'b1, 32'h12345678, 14'd0});
        end
        bus.req_in = 1'b0;
        tick();
        vectors++;
        if (bus.in_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL word_ack_width: in_ack got %b, expected 0", bus.in_ack);
        end
    endtask

    task automatic test_slow_feed();
        logic [7:0] b [4];
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        ack_seen   = 1'b0;
        bus.req_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 10; g++) tick();
            bus.rx_data  = b[k];
            bus.rx_valid = 1'b1;
            tick();
            bus.rx_valid = 1'b0;
        end
        vectors++;
        if (ack_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL slow_early_ack: got %b, expected 0", ack_seen);
        end
        tick();
        vectors++;
        if ({bus.in_ack, bus.in_word} !== {1'b1, 32'hD4C3B2A1}) begin
            miscompares++;
            $display("FAIL slow_result: got %h, expected %h", {bus.in_ack, bus.in_word}, {1'b1, 32'hD4C3B2A1});
        end
        bus.req_in = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic        got_ack;
        logic [7:0]  b0;
        logic [31:0] exp;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        vectors++;
        if ({bus.rx_count, bus.overflow} !== {14'd8192, 1'b0}) begin
            miscompares++;
            $display("FAIL full_no_overflow: got %h, expected %h", {bus.rx_count, bus.overflow}, {14'd8192, 1'b0});
        end
        push_byte(8'hEE);
        vectors++;
        if ({bus.rx_count, bus.overflow} !== {14'd8192, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_set: got %h, expected %h", {bus.rx_count, bus.overflow}, {14'd8192, 1'b1});
        end
        for (int w = 0; w < DEPTH / 4; w++) begin
            bus.req_in = 1'b1;
            got_ack    = 1'b0;
            for (int c = 0; c < 10 && !got_ack; c++) begin
                tick();
                if (bus.in_ack === 1'b1) got_ack = 1'b1;
            end
            bus.req_in = 1'b0;
            b0  = 8'(4 * w);
            exp = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
            vectors++;
            if (!got_ack || bus.in_word !== exp) begin
                miscompares++;
                $display("FAIL wrap_word[%0d]: ack %b word %h, expected ack 1 word %h", w, got_ack, bus.in_word, exp);
            end
            tick();
        end
        vectors++;
        if ({bus.rx_count, bus.overflow} !== {14'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL drain_sticky: got %h, expected %h", {bus.rx_count, bus.overflow}, {14'd0, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        bus.req_in = 1'b1;
        tick();
        tick();
        tick();
        test_reset("reset_mid_collect");
        bus.req_in = 1'b1;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        bus.rx_data  = 8'h04;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        vectors++;
        if (ack_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL fresh_early_ack: got %b, expected 0", ack_seen);
        end
        tick();
        vectors++;
        if ({bus.in_ack, bus.in_word} !== {1'b1, 32'h04030201}) begin
            miscompares++;
            $display("FAIL fresh_result: got %h, expected %h", {bus.in_ack, bus.in_word}, {1'b1, 32'h04030201});
        end
        bus.req_in = 1'b0;
        tick();
    endtask

    task automatic test_out_during_sync();
        bus.req_out  = 1'b1;
        bus.out_byte = 8'h41;
        tick();
        vectors++;
        if ({bus.tx_ready, bus.tx_data, bus.out_ack} !== {1'b1, 8'hAA, 1'b0}) begin
            miscompares++;
            $display("FAIL sync_first: got %h, expected %h", {bus.tx_ready, bus.tx_data, bus.out_ack}, {1'b1, 8'hAA, 1'b0});
        end
        bus.tx_busy = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.tx_ready, bus.tx_data} !== {1'b0, 8'hAA}) begin
            miscompares++;
            $display("FAIL sync_busy: got %h, expected %h", {bus.tx_ready, bus.tx_data}, {1'b0, 8'hAA});
        end
        bus.tx_busy = 1'b0;
        tick();
        vectors++;
        if (bus.tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_to_idle: tx_ready got %b, expected 0", bus.tx_ready);
        end
        tick();
        vectors++;
        if ({bus.tx_ready, bus.tx_data} !== {1'b1, 8'h41}) begin
            miscompares++;
            $display("FAIL out_send: got %h, expected %h", {bus.tx_ready, bus.tx_data}, {1'b1, 8'h41});
        end
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        tick();
        vectors++;
        if ({bus.out_ack, bus.tx_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL out_ack: got %b, expected 10", {bus.out_ack, bus.tx_ready});
        end
        bus.req_out = 1'b0;
        tick();
        vectors++;
        if (bus.out_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL out_ack_width: out_ack got %b, expected 0", bus.out_ack);
        end
    endtask

    initial begin
        ack_seen = 1'b0;
        test_reset("reset_initial");
        test_sync();
        test_word();
        test_slow_feed();
        test_overflow();
        test_reset_mid();
        test_reset("reset_before_out");
        test_out_during_sync();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
